// File: rtl/pc_pkg.sv
// ----------------------------------------------------------------------------
// pc_pkg : shared types, defaults and helpers for the fetch PC generator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pc_pkg;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_e;

  localparam int          PC_MAX_W     = 64;
  localparam logic [31:0] PC_RESET_VEC = 32'h8000_0000;
  localparam int          PC_INC       = 4;

  // Mask that clears the low align_bits bits; callers truncate to their XLEN.
  function automatic logic [PC_MAX_W-1:0] align_mask(input int align_bits);
    logic [PC_MAX_W-1:0] one;
    one = {{(PC_MAX_W-1){1'b0}}, 1'b1};
    return ~((one << align_bits) - one);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_inc.sv
// ----------------------------------------------------------------------------
// pc_inc : combinational PC + INC, wraps modulo 2^XLEN
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_inc #(
  parameter int XLEN = 32,
  parameter int INC  = 4
) (
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_plus_inc_o
);

  assign pc_plus_inc_o = pc_i + XLEN'(INC);

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// ----------------------------------------------------------------------------
// pc_gen : fetch-stage PC register with boot delay, trap/redirect/stall
//          next-PC selection and debug halt/resume
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(PC_RESET_VEC),
  parameter int              INC         = PC_INC,
  parameter int              ALIGN_BITS  = 2,
  parameter int              BOOT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            halt_req_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_inc_o,
  output logic            fetch_valid_o,
  output logic            misalign_o,
  output logic            halted_o,
  output logic [1:0]      state_o
);

  localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST =
    (BOOT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(BOOT_CYCLES - 1);
  localparam logic [XLEN-1:0] MASK = XLEN'(align_mask(ALIGN_BITS));

  pc_state_e        state_q;
  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] boot_cnt_q;
  logic             misalign_q;

  logic [XLEN-1:0]  pc_inc_w;
  logic [XLEN-1:0]  trap_aligned_w;
  logic             redir_misaligned_w;

  pc_inc #(
    .XLEN (XLEN),
    .INC  (INC)
  ) u_pc_inc (
    .pc_i          (pc_q),
    .pc_plus_inc_o (pc_inc_w)
  );

  assign trap_aligned_w     = trap_vec_i & MASK;
  assign redir_misaligned_w = |(redirect_target_i & ~MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PC_BOOT;
      pc_q       <= RESET_VEC;
      boot_cnt_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        PC_BOOT: begin
          if (BOOT_CYCLES == 0 || boot_cnt_q == BOOT_LAST) begin
            state_q <= PC_RUN;
          end else begin
            boot_cnt_q <= boot_cnt_q + CNT_W'(1);
          end
        end
        PC_RUN: begin
          // A PC change this cycle defers halt; the requester holds halt_req_i.
          if (trap_valid_i) begin
            pc_q <= trap_aligned_w;
          end else if (redirect_valid_i && !redir_misaligned_w) begin
            pc_q <= redirect_target_i;
          end else if (redirect_valid_i) begin
            pc_q       <= trap_aligned_w;
            misalign_q <= 1'b1;
          end else if (halt_req_i) begin
            state_q <= PC_HALT;
          end else if (!stall_i) begin
            pc_q <= pc_inc_w;
          end
        end
        PC_HALT: begin
          if (redirect_valid_i && !redir_misaligned_w) begin
            pc_q <= redirect_target_i;
          end
          if (resume_i && !halt_req_i) begin
            state_q <= PC_RUN;
          end
        end
        default: state_q <= PC_BOOT;
      endcase
    end
  end

  assign pc_o          = pc_q;
  assign pc_plus_inc_o = pc_inc_w;
  assign fetch_valid_o = (state_q == PC_RUN);
  assign halted_o      = (state_q == PC_HALT);
  assign misalign_o    = misalign_q;
  assign state_o       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ----------------------------------------------------------------------------
// tb_pc_gen : directed self-checking bench for pc_gen
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        trap_valid_i;
  logic [31:0] trap_vec_i;
  logic        halt_req_i;
  logic        resume_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_inc_o;
  logic        fetch_valid_o;
  logic        misalign_o;
  logic        halted_o;
  logic [1:0]  state_o;

  int chk_cnt = 0;
  int err_cnt = 0;

  pc_gen #(
    .XLEN        (32),
    .RESET_VEC   (32'h8000_0000),
    .INC         (4),
    .ALIGN_BITS  (2),
    .BOOT_CYCLES (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .trap_valid_i      (trap_valid_i),
    .trap_vec_i        (trap_vec_i),
    .halt_req_i        (halt_req_i),
    .resume_i          (resume_i),
    .pc_o              (pc_o),
    .pc_plus_inc_o     (pc_plus_inc_o),
    .fetch_valid_o     (fetch_valid_o),
    .misalign_o        (misalign_o),
    .halted_o          (halted_o),
    .state_o           (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic [31:0] pc,
                              input logic fv, input logic hlt, input logic mis,
                              input logic [1:0] st);
    check({tag, ".pc"},       pc_o,                   pc);
    check({tag, ".fv"},       {31'd0, fetch_valid_o}, {31'd0, fv});
    check({tag, ".halted"},   {31'd0, halted_o},      {31'd0, hlt});
    check({tag, ".misalign"}, {31'd0, misalign_o},    {31'd0, mis});
    check({tag, ".state"},    {30'd0, state_o},       {30'd0, st});
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_target_i = '0;
    trap_valid_i = 1'b0; trap_vec_i = '0; halt_req_i = 1'b0; resume_i = 1'b0;

    for (int i = 0; i < 3; i++) step();
    check_status("reset", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'd0);

    // Boot delay: two cycles of BOOT, inputs ignored.
    rst = 1'b0; halt_req_i = 1'b1; trap_valid_i = 1'b1; trap_vec_i = 32'h1234_5678;
    step();
    check_status("boot1", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'd0);
    halt_req_i = 1'b0; trap_valid_i = 1'b0;
    step();
    check_status("boot2", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 2'd1);
    step();
    check("seq1.pc", pc_o, 32'h8000_0004);
    check("seq1.inc", pc_plus_inc_o, 32'h8000_0008);

    // Wrap through zero.
    redirect_valid_i = 1'b1; redirect_target_i = 32'hFFFF_FFFC;
    step();
    check("wrap.pc", pc_o, 32'hFFFF_FFFC);
    check("wrap.inc", pc_plus_inc_o, 32'h0000_0000);
    redirect_valid_i = 1'b0;
    step();
    check("wrap.zero", pc_o, 32'h0000_0000);

    // Stall holds the PC while still fetching.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.pc", pc_o, 32'h0000_0000);
      check("stall.fv", {31'd0, fetch_valid_o}, 32'd1);
    end
    stall_i = 1'b0;

    // Trap beats redirect and stall; vector gets aligned.
    trap_valid_i = 1'b1; trap_vec_i = 32'h8000_0103;
    redirect_valid_i = 1'b1; redirect_target_i = 32'h8000_0200; stall_i = 1'b1;
    step();
    check_status("prio", 32'h8000_0100, 1'b1, 1'b0, 1'b0, 2'd1);
    trap_valid_i = 1'b0; stall_i = 1'b0;

    // Misaligned redirect becomes a trap with a one-cycle pulse.
    trap_vec_i = 32'h8000_0100; redirect_target_i = 32'h8000_0202;
    step();
    check_status("misal", 32'h8000_0100, 1'b1, 1'b0, 1'b1, 2'd1);
    redirect_valid_i = 1'b0;
    step();
    check_status("misal.after", 32'h8000_0104, 1'b1, 1'b0, 1'b0, 2'd1);

    // Halt request coinciding with a redirect: redirect wins, no halt yet.
    halt_req_i = 1'b1; redirect_valid_i = 1'b1; redirect_target_i = 32'h8000_0300;
    step();
    check_status("halt.defer", 32'h8000_0300, 1'b1, 1'b0, 1'b0, 2'd1);
    redirect_valid_i = 1'b0;
    step();
    check_status("halt.enter", 32'h8000_0300, 1'b0, 1'b1, 1'b0, 2'd2);
    halt_req_i = 1'b0;
    step();
    check_status("halt.hold", 32'h8000_0300, 1'b0, 1'b1, 1'b0, 2'd2);

    // Trap and misaligned redirect are ignored in HALT.
    trap_valid_i = 1'b1; trap_vec_i = 32'h8000_0500;
    step();
    check("halt.trap", pc_o, 32'h8000_0300);
    trap_valid_i = 1'b0;
    redirect_valid_i = 1'b1; redirect_target_i = 32'h8000_0402;
    step();
    check_status("halt.misal", 32'h8000_0300, 1'b0, 1'b1, 1'b0, 2'd2);
    redirect_target_i = 32'h8000_0400;
    step();
    check_status("halt.write", 32'h8000_0400, 1'b0, 1'b1, 1'b0, 2'd2);
    redirect_valid_i = 1'b0;

    // Resume blocked while halt_req_i is still high.
    resume_i = 1'b1; halt_req_i = 1'b1;
    step();
    check_status("halt.block", 32'h8000_0400, 1'b0, 1'b1, 1'b0, 2'd2);
    resume_i = 1'b0; halt_req_i = 1'b0;

    // Reset while halted restarts the boot delay.
    rst = 1'b1;
    step();
    check_status("rst.halt", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    step();
    check_status("reboot1", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'd0);
    step();
    check_status("reboot2", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 2'd1);

    // Halt again, then redirect and resume in the same cycle.
    halt_req_i = 1'b1;
    step();
    check_status("halt2", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 2'd2);
    halt_req_i = 1'b0; resume_i = 1'b1;
    redirect_valid_i = 1'b1; redirect_target_i = 32'h8000_0400;
    step();
    check_status("resume", 32'h8000_0400, 1'b1, 1'b0, 1'b0, 2'd1);
    resume_i = 1'b0; redirect_valid_i = 1'b0;
    step();
    check_status("resume.seq", 32'h8000_0404, 1'b1, 1'b0, 1'b0, 2'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generation unit for the fetch stage of the single-cycle RISC-V core. Holds the architectural PC register and produces the fetch PC and PC+INC. Selects the next PC from trap, redirect (branch/jump), stall or sequential sources. Adds a boot-delay phase and a debug halt/resume state, with misaligned-target detection.

Parameters:
XLEN, 32, PC width in bits
RESET_VEC, 32'h8000_0000, PC value loaded on reset (XLEN bits)
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, low PC bits that must be zero (2 = RV32I, 1 = with C extension)
BOOT_CYCLES, 2, cycles spent in BOOT after reset before fetch starts (0 allowed)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
stall_i  in  1  hold PC (pipeline/memory stall)
redirect_valid_i  in  1  branch/jump taken this cycle
redirect_target_i  in  XLEN  branch/jump target
trap_valid_i  in  1  exception/interrupt taken this cycle
trap_vec_i  in  XLEN  trap handler address (mtvec)
halt_req_i  in  1  debug halt request
resume_i  in  1  debug resume request
pc_o  out  XLEN  current fetch PC (registered)
pc_plus_inc_o  out  XLEN  pc_o + INC, combinational, wraps mod 2^XLEN
fetch_valid_o  out  1  pc_o is a valid fetch address this cycle
misalign_o  out  1  one-cycle pulse: misaligned redirect was converted to trap
halted_o  out  1  unit is in HALT
state_o  out  2  current state (BOOT/RUN/HALT), for debug

Behaviour:
- Reset (rst=1 at edge): pc=RESET_VEC, state=BOOT, boot_cnt=0, misalign_o=0. Outputs while in reset/BOOT: fetch_valid_o=0, halted_o=0. rst overrides every other input, including mid-operation in any state.
- fetch_valid_o = (state==RUN); halted_o = (state==HALT); both decoded from state, no extra latency.
- BOOT: pc held; boot_cnt increments each cycle; transition to RUN on the edge where boot_cnt==BOOT_CYCLES-1. If BOOT_CYCLES==0, transition to RUN on the first edge after reset is released. All other inputs are ignored.
- RUN, next-PC priority (one edge, registered):
  1. trap_valid_i: pc <= trap_vec_i with low ALIGN_BITS forced to 0.
  2. redirect_valid_i with aligned target (low ALIGN_BITS == 0): pc <= redirect_target_i.
  3. redirect_valid_i with misaligned target: pc <= aligned trap_vec_i; misalign_o=1 for exactly the next cycle.
  4. halt_req_i: state <= HALT; pc held.
  5. stall_i: pc held.
  6. Otherwise: pc <= pc + INC. Wraps mod 2^XLEN, with no flag.
- Trap and redirect override stall. Halt_req together with trap or redirect: the PC update happens first, and halt is not taken that cycle. The requester keeps halt_req_i high.
- HALT: pc held, fetch_valid_o=0.
  - redirect_valid_i loads pc (debugger PC write). Aligned targets only; a misaligned target is ignored with no misalign pulse.
  - trap_valid_i and stall_i are ignored.
  - resume_i=1 with halt_req_i=0 -> RUN next edge. If both are high, stay in HALT.
  - A redirect and resume in the same cycle both take effect.
- misalign_o is registered and cleared every cycle unless case 3 fires.
- No combinational path from any input to pc_o.

Decomposition:
- Shared package pc_pkg:
  - pc_state_e enum (PC_BOOT=2'd0, PC_RUN=2'd1, PC_HALT=2'd2).
  - Default constants PC_RESET_VEC and PC_INC.
  - align_mask function.
- One sub-module, pc_inc: parametrised XLEN combinational incrementer producing pc+INC. It is instantiated once, and its output drives both pc_plus_inc_o and the sequential next-PC.

Test Plan:
- Reset/boot: rst=1 for 3 cycles, then 0 -> pc_o=0x8000_0000 and fetch_valid_o=0 for 2 cycles. Then fetch_valid_o=1, and on the next edge pc_o=0x8000_0004.
- Wrap and stall: redirect to 0xFFFF_FFFC, then free-run -> pc_o goes 0xFFFF_FFFC, then 0x0000_0000. With stall_i=1 for 3 cycles, pc_o is held at 0x0000_0000 and fetch_valid_o stays 1.
- Priority: trap_valid_i=1 (trap_vec_i=0x8000_0103), redirect to 0x8000_0200 and stall_i=1 in the same cycle -> pc_o=0x8000_0100, misalign_o=0.
- Misaligned redirect to 0x8000_0202 (trap_vec_i=0x8000_0100) -> pc_o=0x8000_0100 and misalign_o=1 for exactly one cycle, then 0.
- Halt/resume: halt_req_i pulse -> halted_o=1, fetch_valid_o=0, pc held. A redirect to 0x8000_0400 in HALT gives pc_o=0x8000_0400, still halted. Resume -> RUN, then pc_o 0x8000_0404 on the next edge.
- Reset mid-operation: assert rst while in HALT at pc 0x8000_0400 -> next edge pc_o=0x8000_0000, state BOOT, halted_o=0, misalign_o=0, boot delay repeats.
